// File: rtl/pdm_mic_capture_if.sv
// Output word stream of the PDM capture block: one packed channel word plus its
// channel index, moved by a valid/ready handshake.
interface pdm_mic_capture_if #(
    parameter int WORD_BITS = 16,
    parameter int CHAN_BITS = 3
);
    logic [WORD_BITS-1:0] data;
    logic [CHAN_BITS-1:0] chan;
    logic                 valid;
    logic                 ready;

    modport master (output data, chan, valid, input ready);
    modport slave  (input data, chan, valid, output ready);
endinterface

// File: rtl/pdm_mic_capture.sv
// Stereo PDM capture: waits for a settled PLL, generates mic_clk, packs L/R bits
// per line into words and streams complete frames out through a word FIFO.
module pdm_mic_capture #(
    parameter int CLK_DIV    = 16,
    parameter int NUM_MICS   = 4,
    parameter int WORD_BITS  = 16,
    parameter int FIFO_WORDS = 32,
    parameter int LOCK_WAIT  = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pll_locked_i,
    input  logic [NUM_MICS-1:0] pdm_data_i,
    output logic                mic_clk_o,
    input  logic                ovf_clr_i,
    output logic                overflow_o,
    output logic                running_o,
    pdm_mic_capture_if.master   m
);
    localparam int NCH = 2 * NUM_MICS;
    localparam int CW  = $clog2(NCH);
    localparam int PW  = $clog2(CLK_DIV);
    localparam int BW  = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam int AW  = $clog2(FIFO_WORDS);
    localparam int LW  = $clog2(LOCK_WAIT + 1);

    typedef enum logic {WAIT_LOCK, RUN} state_t;

    state_t                state_q, state_d;
    logic [LW-1:0]         lock_cnt_q, lock_cnt_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  mic_clk_q, mic_clk_d;
    logic                  running_q, running_d;
    logic                  overflow_q, overflow_d;
    logic [WORD_BITS-1:0]  l_sr_q [NUM_MICS];
    logic [WORD_BITS-1:0]  l_sr_d [NUM_MICS];
    logic [WORD_BITS-1:0]  r_sr_q [NUM_MICS];
    logic [WORD_BITS-1:0]  r_sr_d [NUM_MICS];
    logic [WORD_BITS-1:0]  hold_q [NCH];
    logic [WORD_BITS-1:0]  hold_d [NCH];
    logic [CW-1:0]         unload_idx_q, unload_idx_d;
    logic                  unload_busy_q, unload_busy_d;
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [WORD_BITS-1:0]  mem_data_q [FIFO_WORDS];
    logic [CW-1:0]         mem_chan_q [FIFO_WORDS];

    logic frame_done;
    logic push;
    logic pop;
    int   used;

    assign m.valid    = (wr_ptr_q != rd_ptr_q);
    assign m.data     = m.valid ? mem_data_q[rd_ptr_q[AW-1:0]] : '0;
    assign m.chan     = m.valid ? mem_chan_q[rd_ptr_q[AW-1:0]] : '0;
    assign pop        = m.valid & m.ready;
    assign mic_clk_o  = mic_clk_q;
    assign running_o  = running_q;
    assign overflow_o = overflow_q;

    always_comb begin
        state_d       = state_q;
        lock_cnt_d    = lock_cnt_q;
        phase_d       = phase_q;
        bit_cnt_d     = bit_cnt_q;
        l_sr_d        = l_sr_q;
        r_sr_d        = r_sr_q;
        hold_d        = hold_q;
        unload_idx_d  = unload_idx_q;
        unload_busy_d = unload_busy_q;
        overflow_d    = overflow_q & ~ovf_clr_i;
        frame_done    = 1'b0;
        push          = 1'b0;

        case (state_q)
            WAIT_LOCK: begin
                phase_d   = '0;
                bit_cnt_d = '0;
                if (!pll_locked_i) begin
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LW'(LOCK_WAIT - 1)) begin
                    lock_cnt_d = '0;
                    state_d    = RUN;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!pll_locked_i) begin
                    // Lock lost: abandon the partial frame, keep whatever is already queued.
                    state_d   = WAIT_LOCK;
                    phase_d   = '0;
                    bit_cnt_d = '0;
                end else begin
                    phase_d = (phase_q == PW'(CLK_DIV - 1)) ? '0 : phase_q + 1'b1;
                    if (phase_q == PW'(CLK_DIV / 2 - 1)) begin
                        for (int i = 0; i < NUM_MICS; i++)
                            l_sr_d[i] = {l_sr_q[i][WORD_BITS-2:0], pdm_data_i[i]};
                    end
                    if (phase_q == PW'(CLK_DIV - 1)) begin
                        for (int i = 0; i < NUM_MICS; i++)
                            r_sr_d[i] = {r_sr_q[i][WORD_BITS-2:0], pdm_data_i[i]};
                        if (bit_cnt_q == BW'(WORD_BITS - 1)) begin
                            bit_cnt_d  = '0;
                            frame_done = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = WAIT_LOCK;
        endcase

        if (unload_busy_q) begin
            push = 1'b1;
            if (unload_idx_q == CW'(NCH - 1)) begin
                unload_busy_d = 1'b0;
                unload_idx_d  = '0;
            end else begin
                unload_idx_d = unload_idx_q + 1'b1;
            end
        end

        // Words still waiting in the unloader count as occupied, so a frame is all-or-nothing.
        used = int'(wr_ptr_q - rd_ptr_q) + (unload_busy_q ? (NCH - int'(unload_idx_q)) : 0);
        if (frame_done) begin
            if (used <= FIFO_WORDS - NCH) begin
                for (int i = 0; i < NUM_MICS; i++) begin
                    hold_d[2*i]   = l_sr_d[i];
                    hold_d[2*i+1] = r_sr_d[i];
                end
                unload_busy_d = 1'b1;
                unload_idx_d  = '0;
            end else begin
                overflow_d = 1'b1;
            end
        end

        wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop};
        running_d = (state_d == RUN);
        mic_clk_d = (state_d == RUN) && (phase_d >= PW'(CLK_DIV / 2));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= WAIT_LOCK;
            lock_cnt_q    <= '0;
            phase_q       <= '0;
            bit_cnt_q     <= '0;
            mic_clk_q     <= 1'b0;
            running_q     <= 1'b0;
            overflow_q    <= 1'b0;
            l_sr_q        <= '{default: '0};
            r_sr_q        <= '{default: '0};
            hold_q        <= '{default: '0};
            unload_idx_q  <= '0;
            unload_busy_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            lock_cnt_q    <= lock_cnt_d;
            phase_q       <= phase_d;
            bit_cnt_q     <= bit_cnt_d;
            mic_clk_q     <= mic_clk_d;
            running_q     <= running_d;
            overflow_q    <= overflow_d;
            l_sr_q        <= l_sr_d;
            r_sr_q        <= r_sr_d;
            hold_q        <= hold_d;
            unload_idx_q  <= unload_idx_d;
            unload_busy_q <= unload_busy_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q[AW-1:0]] <= hold_q[unload_idx_q];
            mem_chan_q[wr_ptr_q[AW-1:0]] <= unload_idx_q;
        end
    end
endmodule
